// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter that shares one fixed-latency memory port between caches A and B.
// Each transaction walks IDLE -> ISSUE -> WAIT (MEM_DELAY cycles) -> RESP -> IDLE.
module mem_arbiter #(
  parameter int unsigned ADDRESSBIT = 16,
  parameter int unsigned WORDSIZE   = 32,
  parameter int unsigned MEM_DELAY  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reqA,
  input  logic                  reqB,
  input  logic                  rdwtA,
  input  logic                  rdwtB,
  input  logic [ADDRESSBIT-1:0] addrA,
  input  logic [ADDRESSBIT-1:0] addrB,
  input  logic [WORDSIZE-1:0]   dataInA,
  input  logic [WORDSIZE-1:0]   dataInB,
  output logic                  gntA,
  output logic                  gntB,
  output logic                  ackA,
  output logic                  ackB,
  output logic [WORDSIZE-1:0]   dataOutA,
  output logic [WORDSIZE-1:0]   dataOutB,
  output logic [ADDRESSBIT-1:0] mem_addr,
  output logic [WORDSIZE-1:0]   mem_dataIn,
  output logic                  mem_rdwt,
  input  logic [WORDSIZE-1:0]   mem_dataOut,
  output logic                  busy
);

  localparam logic RD   = 1'b0;
  localparam logic WT   = 1'b1;
  localparam logic OwnA = 1'b0;
  localparam logic OwnB = 1'b1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  rdwt_q, rdwt_d;
  logic [ADDRESSBIT-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0]   data_q, data_d;
  logic [WORDSIZE-1:0]   dout_a_q, dout_a_d;
  logic [WORDSIZE-1:0]   dout_b_q, dout_b_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  grant_b;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rdwt_d       = rdwt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dout_a_d     = dout_a_q;
    dout_b_d     = dout_b_q;
    cnt_d        = cnt_q;
    grant_b      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (reqA || reqB) begin
          // B wins a tie only when A was the previous owner.
          grant_b      = reqB && (!reqA || (last_grant_q == OwnA));
          last_grant_d = grant_b ? OwnB : OwnA;
          rdwt_d       = grant_b ? rdwtB : rdwtA;
          addr_d       = grant_b ? addrB : addrA;
          data_d       = grant_b ? dataInB : dataInA;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = 8'(MEM_DELAY);
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          if (rdwt_q == RD) begin
            if (last_grant_q == OwnB) dout_b_d = mem_dataOut;
            else                      dout_a_d = mem_dataOut;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= OwnB;
      rdwt_q       <= RD;
      addr_q       <= '0;
      data_q       <= '0;
      dout_a_q     <= '0;
      dout_b_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rdwt_q       <= rdwt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      dout_a_q     <= dout_a_d;
      dout_b_q     <= dout_b_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decode straight from state, so asynchronous reset clears them at once.
  always_comb begin
    busy       = (state_q != StIdle);
    gntA       = busy && (last_grant_q == OwnA);
    gntB       = busy && (last_grant_q == OwnB);
    ackA       = (state_q == StResp) && (last_grant_q == OwnA);
    ackB       = (state_q == StResp) && (last_grant_q == OwnB);
    mem_rdwt   = ((state_q == StIssue) && (rdwt_q == WT)) ? WT : RD;
    mem_addr   = addr_q;
    mem_dataIn = data_q;
    dataOutA   = dout_a_q;
    dataOutB   = dout_b_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for mem_arbiter: requesters push expectations, a negedge monitor
// checks arbitration, latency, memory-port traffic and returned data.
module tb_mem_arbiter;

  localparam int unsigned D  = 4;
  localparam logic        RD = 1'b0;
  localparam logic        WT = 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req [2];
  logic        rw  [2];
  logic [15:0] addr[2];
  logic [31:0] din [2];
  logic        gnt [2];
  logic        ack [2];
  logic [31:0] dout[2];
  logic [15:0] m_addr;
  logic [31:0] m_din, m_dout;
  logic        m_rw, busy;

  logic        r1_req, r1_rw, z_req, z_rw;
  logic [15:0] r1_addr, z_addr, m1_addr;
  logic [31:0] r1_din, z_din, m1_din, m1_dout, d1a, d1b;
  logic        g1a, g1b, a1a, a1b, m1_rw, busy1;

  mem_arbiter #(.ADDRESSBIT(16), .WORDSIZE(32), .MEM_DELAY(D)) dut (
    .clk(clk), .rst(rst),
    .reqA(req[0]), .reqB(req[1]), .rdwtA(rw[0]), .rdwtB(rw[1]),
    .addrA(addr[0]), .addrB(addr[1]), .dataInA(din[0]), .dataInB(din[1]),
    .gntA(gnt[0]), .gntB(gnt[1]), .ackA(ack[0]), .ackB(ack[1]),
    .dataOutA(dout[0]), .dataOutB(dout[1]),
    .mem_addr(m_addr), .mem_dataIn(m_din), .mem_rdwt(m_rw), .mem_dataOut(m_dout),
    .busy(busy)
  );

  mem_arbiter #(.ADDRESSBIT(16), .WORDSIZE(32), .MEM_DELAY(1)) dut1 (
    .clk(clk), .rst(rst),
    .reqA(r1_req), .reqB(z_req), .rdwtA(r1_rw), .rdwtB(z_rw),
    .addrA(r1_addr), .addrB(z_addr), .dataInA(r1_din), .dataInB(z_din),
    .gntA(g1a), .gntB(g1b), .ackA(a1a), .ackB(a1b),
    .dataOutA(d1a), .dataOutB(d1b),
    .mem_addr(m1_addr), .mem_dataIn(m1_din), .mem_rdwt(m1_rw), .mem_dataOut(m1_dout),
    .busy(busy1)
  );

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Memory device: combinational read, write sampled on the rising edge.
  logic [31:0] mem [0:65535];
  logic        init_done = 1'b0;
  assign m_dout  = mem[m_addr];
  assign m1_dout = mem[m1_addr];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
      mem[16'h0010] <= 32'hDEADBEEF;
      init_done     <= 1'b1;
    end else begin
      if (m_rw == WT)  mem[m_addr]  <= m_din;
      if (m1_rw == WT) mem[m1_addr] <= m1_din;
    end
  end

  // Reference model: memory contents as seen at transaction level.
  logic [31:0] ref_mem [logic [15:0]];
  function automatic logic [31:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (a == 16'h0010) return 32'hDEADBEEF;
    return pat(a);
  endfunction

  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] out;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] last_out[2];
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int p, input logic w, input logic [15:0] a,
                          input logic [31:0] d, input bit commit);
    exp_t e;
    e.rw   = w;
    e.addr = a;
    e.data = d;
    if (w == WT) begin
      if (commit) ref_mem[a] = d;
      e.out = last_out[p];
    end else begin
      e.out       = ref_rd(a);
      last_out[p] = e.out;
    end
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge on which ack is seen.
  task automatic txn(input int p, input logic w, input logic [15:0] a, input logic [31:0] d,
                     input bit scr, input bit keep);
    int n;
    push_exp(p, w, a, d, 1'b1);
    rw[p] = w; addr[p] = a; din[p] = d; req[p] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!gnt[p] && n < 200);
    if (!gnt[p]) chk("gnt_timeout", gnt[p], 1);
    if (scr) begin
      addr[p] = 16'($urandom); din[p] = $urandom; rw[p] = 1'($urandom);
    end
    n = 0;
    while (!ack[p] && n < 300) begin @(negedge clk); n++; end
    if (!ack[p]) chk("ack_timeout", ack[p], 1);
    if (!keep) req[p] = 1'b0;
  endtask

  // Monitor
  logic smp_req[2];
  logic prev_busy;
  logic last_g;
  logic eo;
  int   gcnt, wtcnt;
  exp_t me;
  bit   have;

  always @(posedge clk) begin
    smp_req[0] <= req[0];
    smp_req[1] <= req[1];
  end

  always @(negedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      prev_busy = 1'b0; last_g = 1'b1; gcnt = 0; wtcnt = 0;
    end else begin
      chk("gnt_exclusive", 32'(gnt[0] & gnt[1]), 0);
      if (!prev_busy) begin
        if (smp_req[0] || smp_req[1]) begin
          eo = (smp_req[0] && smp_req[1]) ? !last_g : smp_req[1];
          chk("grant_A", 32'(gnt[0]), 32'(!eo));
          chk("grant_B", 32'(gnt[1]), 32'(eo));
          last_g = eo; gcnt = 0; wtcnt = 0;
          have = (eo == 1'b0) ? (q0.size() > 0) : (q1.size() > 0);
          if (have) begin
            me = (eo == 1'b0) ? q0[0] : q1[0];
            chk("issue_addr", 32'(m_addr), 32'(me.addr));
            chk("issue_rdwt", 32'(m_rw), 32'(me.rw));
            if (me.rw == WT) chk("issue_data", m_din, me.data);
          end else chk("grant_unexpected", 1, 0);
        end else chk("idle_stay", 32'(busy), 0);
      end
      if (busy) gcnt++;
      if (m_rw == WT) wtcnt++;
      if (!busy) chk("rdwt_idle", 32'(m_rw), 32'(RD));
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          chk("ack_owner", 32'(p), 32'(last_g));
          chk("latency", 32'(gcnt), D + 2);
          have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
          if (have) begin
            me = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk("wt_cycles", 32'(wtcnt), 32'(me.rw));
            chk(p == 0 ? "dataOutA" : "dataOutB", dout[p], me.out);
          end else chk("ack_unexpected", 1, 0);
        end
      end
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  logic [6:0] g1e, a1e;

  initial begin
    for (int p = 0; p < 2; p++) begin
      req[p] = 0; rw[p] = RD; addr[p] = '0; din[p] = '0; last_out[p] = '0;
    end
    r1_req = 0; r1_rw = RD; r1_addr = '0; r1_din = '0;
    z_req = 0; z_rw = RD; z_addr = '0; z_din = '0;
    repeat (3) @(negedge clk);
    chk("rst_gntA", 32'(gnt[0]), 0);     chk("rst_gntB", 32'(gnt[1]), 0);
    chk("rst_ackA", 32'(ack[0]), 0);     chk("rst_ackB", 32'(ack[1]), 0);
    chk("rst_busy", 32'(busy), 0);       chk("rst_doutA", dout[0], 0);
    chk("rst_doutB", dout[1], 0);        chk("rst_mem_addr", 32'(m_addr), 0);
    chk("rst_mem_din", m_din, 0);        chk("rst_mem_rdwt", 32'(m_rw), 32'(RD));
    #2 rst = 1'b0;
    @(negedge clk);

    // Simultaneous held requests after reset: A, B, A, B.
    fork
      begin
        txn(0, RD, 16'h0101, 32'h0, 0, 1);
        txn(0, WT, 16'h0102, 32'hA5A5_0102, 0, 0);
      end
      begin
        txn(1, RD, 16'h8101, 32'h0, 0, 1);
        txn(1, RD, 16'h8102, 32'h0, 0, 0);
      end
    join
    @(negedge clk);

    txn(0, RD, 16'h0010, 32'h0, 0, 0);
    @(negedge clk);
    txn(1, WT, 16'h0020, 32'h12345678, 0, 0);
    txn(1, RD, 16'h0020, 32'h0, 0, 0);
    @(negedge clk);
    txn(0, RD, 16'h0103, 32'h0, 1, 0);

    fork
      for (int i = 0; i < 40; i++) begin
        bit k;
        k = (i != 39) && ($urandom_range(0, 1) == 1);
        txn(0, 1'($urandom), 16'h0100 | 16'($urandom_range(0, 15)), $urandom,
            1'($urandom), k);
        if (!k) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int j = 0; j < 40; j++) begin
        bit k;
        k = (j != 39) && ($urandom_range(0, 1) == 1);
        txn(1, 1'($urandom), 16'h8100 | 16'($urandom_range(0, 15)), $urandom,
            1'($urandom), k);
        if (!k) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    join
    repeat (2) @(negedge clk);

    // Reset during WAIT of an A write: the write already reached memory at the end of ISSUE.
    push_exp(0, WT, 16'h0105, 32'hCAFEF00D, 1'b1);
    rw[0] = WT; addr[0] = 16'h0105; din[0] = 32'hCAFEF00D; req[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_gntA", 32'(gnt[0]), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdwt", 32'(m_rw), 32'(RD));
    chk("abort_doutA", dout[0], 0);
    req[0] = 1'b0; last_out[0] = '0; last_out[1] = '0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Reset during ISSUE of a B write: the write must never reach memory.
    push_exp(1, WT, 16'h8107, 32'h0BAD0BAD, 1'b0);
    rw[1] = WT; addr[1] = 16'h8107; din[1] = 32'h0BAD0BAD; req[1] = 1'b1;
    @(negedge clk);
    chk("issue_wt_seen", 32'(m_rw), 32'(WT));
    #2 rst = 1'b1;
    #1;
    chk("abort_issue_rdwt", 32'(m_rw), 32'(RD));
    chk("abort_issue_gntB", 32'(gnt[1]), 0);
    req[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    txn(1, RD, 16'h8107, 32'h0, 0, 0);
    txn(1, RD, 16'h0105, 32'h0, 0, 0);
    repeat (2) @(negedge clk);

    // MEM_DELAY = 1 instance: two back-to-back reads from a held request.
    g1e = 7'b1110111;
    a1e = 7'b1000100;
    r1_req = 1'b1; r1_rw = RD; r1_addr = 16'hFFFF;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("d1_gnt", 32'(g1a), 32'(g1e[c]));
      chk("d1_ack", 32'(a1a), 32'(a1e[c]));
      chk("d1_busy", 32'(busy1), 32'(g1e[c]));
      if (c == 2) begin
        chk("d1_data_ffff", d1a, ref_rd(16'hFFFF));
        r1_addr = 16'hFFFE;
      end
      if (c == 6) begin
        chk("d1_data_fffe", d1a, ref_rd(16'hFFFE));
        r1_req = 1'b0;
      end
    end
    @(negedge clk);
    chk("d1_idle", 32'(busy1), 0);
    chk("q_drained", 32'(q0.size() + q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
